// File: rtl/pack_src_arbiter.sv
// Round-robin packet scheduler: grants one source a whole packet (header + payload)
// onto the shared packer input, then holds an idle gap for the packer buffer swap.
module pack_src_arbiter #(
  parameter int N_SRC         = 4,
  parameter int PAYLOAD_BYTES = 242,
  parameter int GAP_CYCLES    = 2,
  parameter int SRC_W         = $clog2(N_SRC)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_SRC*8-1:0] i_src_data,
  input  logic [N_SRC-1:0]   i_src_valid,
  output logic [N_SRC-1:0]   o_src_ready,
  output logic [7:0]         o_pk_data,
  output logic               o_pk_valid,
  input  logic               i_pk_ready,
  output logic [SRC_W-1:0]   o_grant_id,
  output logic               o_busy,
  output logic [15:0]        o_pkt_count
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {ARB, HEADER, PAYLOAD, GAP} state_t;

  state_t             state_q;
  logic [SRC_W-1:0]   grant_q;
  logic [7:0]         hdr_q, hdr_d;
  logic [2:0]         seq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [15:0]        pkt_q;

  logic               pick_vld;
  logic [SRC_W-1:0]   pick, idx;
  logic [7:0]         src_byte;
  logic               src_vld;
  logic               last_byte;

  // Descending scan so the smallest offset from the last grant wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = grant_q;
    idx      = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      idx = SRC_W'((int'(grant_q) + i) % N_SRC);
      if (i_src_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign hdr_d = {1'b1, seq_q, 4'(pick)};

  always_comb begin
    src_byte = '0;
    for (int k = 0; k < N_SRC; k++)
      if (grant_q == SRC_W'(k)) src_byte = i_src_data[8*k +: 8];
  end

  assign src_vld   = i_src_valid[grant_q];
  assign last_byte = (cnt_q == CNT_W'(PAYLOAD_BYTES - 1));

  always_comb begin
    o_src_ready = '0;
    if (state_q == PAYLOAD) o_src_ready[grant_q] = i_pk_ready;
  end

  // Payload is a zero-latency pass-through; the header comes from its register.
  assign o_pk_valid  = (state_q == HEADER) || ((state_q == PAYLOAD) && src_vld);
  assign o_pk_data   = (state_q == PAYLOAD) ? src_byte : hdr_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = (state_q != ARB);
  assign o_pkt_count = pkt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ARB;
      grant_q <= SRC_W'(N_SRC - 1);
      hdr_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      pkt_q   <= '0;
    end else begin
      case (state_q)
        ARB: if (pick_vld) begin
          grant_q <= pick;
          hdr_q   <= hdr_d;
          state_q <= HEADER;
        end
        HEADER: if (i_pk_ready) begin
          cnt_q   <= '0;
          state_q <= PAYLOAD;
        end
        PAYLOAD: if (src_vld && i_pk_ready) begin
          if (last_byte) begin
            seq_q   <= seq_q + 3'd1;
            pkt_q   <= pkt_q + 16'd1;
            gap_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          // Saturate so a long packer stall still exits once ready returns.
          if (gap_q != GAP_W'(GAP_CYCLES - 1)) gap_q <= gap_q + 1'b1;
          else if (i_pk_ready) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_src_arbiter.sv
// Directed bench for pack_src_arbiter: byte-counting sources, a packer-side transfer log,
// and one task per scenario with inline expected-value comparisons.
module tb_pack_src_arbiter;
  localparam int N   = 4;
  localparam int PB  = 242;
  localparam int PKT = PB + 1;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic [N*8-1:0] i_src_data;
  logic [N-1:0]   i_src_valid = '0;
  logic [N-1:0]   o_src_ready;
  logic [7:0]     o_pk_data;
  logic           o_pk_valid;
  logic           i_pk_ready = 1'b1;
  logic [1:0]     o_grant_id;
  logic           o_busy;
  logic [15:0]    o_pkt_count;

  int errors = 0;
  int checks = 0;

  pack_src_arbiter #(.N_SRC(N), .PAYLOAD_BYTES(PB), .GAP_CYCLES(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_src_data(i_src_data), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
    .o_pk_data(o_pk_data), .o_pk_valid(o_pk_valid), .i_pk_ready(i_pk_ready),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_pkt_count(o_pkt_count)
  );

  always #5 i_clk = ~i_clk;

  // Each source emits 0,1,2,... advancing on its own handshakes.
  logic [7:0] src_cnt [N];
  logic [N-1:0] sfire = '0;
  always_comb for (int k = 0; k < N; k++) i_src_data[8*k +: 8] = src_cnt[k];

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) for (int k = 0; k < N; k++) src_cnt[k] <= 8'h00;
    else for (int k = 0; k < N; k++) if (sfire[k]) src_cnt[k] <= src_cnt[k] + 8'h01;
  end

  // Transfer log sampled mid-cycle; cleared while reset is held.
  logic [7:0] pk_q [$];
  logic [1:0] g_q  [$];
  int         t_q  [$];
  int         cyc = 0;
  logic [N-1:0] ready_seen = '0;
  logic         ready_bad = 1'b0;

  always @(negedge i_clk) begin
    cyc++;
    if (i_reset) begin
      pk_q.delete(); g_q.delete(); t_q.delete();
      ready_seen = '0; ready_bad = 1'b0; sfire = '0;
    end else begin
      if (o_pk_valid && i_pk_ready) begin
        pk_q.push_back(o_pk_data); g_q.push_back(o_grant_id); t_q.push_back(cyc);
      end
      if ($countones(o_src_ready) > 1) ready_bad = 1'b1;
      ready_seen = ready_seen | o_src_ready;
      sfire = i_src_valid & o_src_ready;
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1; i_src_valid = '0; i_pk_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int c = 0;
    while (pk_q.size() < n && c < budget) begin step(); c++; end
    checks++;
    if (pk_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d transfers, need %0d", name, pk_q.size(), n);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    checks += 6;
    if (o_pk_valid !== 1'b0) begin errors++; $display("FAIL rst_pk_valid: got %b want 0", o_pk_valid); end
    if (o_src_ready !== 4'b0) begin errors++; $display("FAIL rst_src_ready: got %b want 0000", o_src_ready); end
    if (o_grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant: got %0d want 3", o_grant_id); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    if (o_pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", o_pkt_count); end
    if (o_pk_data !== 8'h00) begin errors++; $display("FAIL rst_pk_data: got %h want 00", o_pk_data); end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_single();
    int bad = 0;
    i_src_valid = 4'b0100;
    wait_xfers(PKT, 400, "single");
    checks += 4;
    if (pk_q[0] !== 8'h82) begin errors++; $display("FAIL single_hdr: got %h want 82", pk_q[0]); end
    for (int i = 1; i < PKT; i++) if (pk_q[i] !== 8'(i - 1)) bad++;
    if (bad != 0) begin errors++; $display("FAIL single_payload: %0d bytes wrong, want 0", bad); end
    if (o_pk_valid !== 1'b0) begin errors++; $display("FAIL single_gap0: valid %b want 0", o_pk_valid); end
    if (o_pkt_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", o_pkt_count); end
    step();
    checks++;
    if (o_pk_valid !== 1'b0) begin errors++; $display("FAIL single_gap1: valid %b want 0", o_pk_valid); end
    i_src_valid = '0;
    repeat (3) step();
    checks += 2;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b want 0", o_busy); end
    if (pk_q.size() != PKT) begin errors++; $display("FAIL single_len: got %0d transfers want %0d", pk_q.size(), PKT); end
  endtask

  task automatic test_rr();
    logic [7:0] exp_h [5];
    int bad_g = 0, bad_t = 0, bad_gap = 0;
    exp_h = '{8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC0};
    apply_reset();
    i_src_valid = 4'hF;
    wait_xfers(5 * PKT, 1400, "rr");
    i_src_valid = '0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (pk_q[k*PKT] !== exp_h[k]) begin
        errors++; $display("FAIL rr_hdr%0d: got %h want %h", k, pk_q[k*PKT], exp_h[k]);
      end
      for (int i = 0; i < PKT; i++) if (g_q[k*PKT + i] !== 2'(k % 4)) bad_g++;
      if (t_q[k*PKT + PB] - t_q[k*PKT] != PB) bad_t++;
      if (k < 4 && t_q[(k+1)*PKT] - t_q[k*PKT + PB] < 3) bad_gap++;
    end
    checks += 5;
    if (bad_g != 0) begin errors++; $display("FAIL rr_interleave: %0d bytes from wrong source", bad_g); end
    if (bad_t != 0) begin errors++; $display("FAIL rr_pkt_len: %0d packets not contiguous 243", bad_t); end
    if (bad_gap != 0) begin errors++; $display("FAIL rr_gap: %0d short gaps", bad_gap); end
    if (ready_bad !== 1'b0) begin errors++; $display("FAIL rr_onehot: ready not one-hot/zero"); end
    if (pk_q[4*PKT + 1] !== 8'hF2) begin errors++; $display("FAIL rr_src0_resume: got %h want f2", pk_q[4*PKT + 1]); end
  endtask

  task automatic test_stall();
    int c = 0, n0, bad = 0;
    apply_reset();
    i_src_valid = 4'b0010;
    step(); step();
    i_src_valid = 4'b1011;
    while (src_cnt[1] != 8'd100 && c < 300) begin step(); c++; end
    checks++;
    if (src_cnt[1] != 8'd100) begin errors++; $display("FAIL stall_reach: src1 count %0d want 100", src_cnt[1]); end
    n0 = pk_q.size();
    i_src_valid[1] = 1'b0;
    repeat (5) step();
    checks++;
    if (pk_q.size() != n0) begin errors++; $display("FAIL stall_bubble: got %0d transfers want %0d", pk_q.size(), n0); end
    i_src_valid[1] = 1'b1;
    wait_xfers(PKT, 400, "stall");
    i_src_valid = '0;
    for (int i = 1; i < PKT; i++) if (pk_q[i] !== 8'(i - 1)) bad++;
    checks += 4;
    if (pk_q[0] !== 8'h81) begin errors++; $display("FAIL stall_hdr: got %h want 81", pk_q[0]); end
    if (bad != 0) begin errors++; $display("FAIL stall_payload: %0d bytes wrong", bad); end
    if (ready_seen !== 4'b0010) begin errors++; $display("FAIL stall_ready_seen: got %b want 0010", ready_seen); end
    if (o_pkt_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d want 1", o_pkt_count); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    apply_reset();
    i_pk_ready = 1'b0;
    i_src_valid = 4'b0001;
    step();
    repeat (10) begin
      if (o_pk_valid !== 1'b1 || o_pk_data !== 8'h80) bad++;
      step();
    end
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL bp_hdr_hold: %0d unstable cycles", bad); end
    if (pk_q.size() != 0) begin errors++; $display("FAIL bp_no_xfer: got %0d transfers want 0", pk_q.size()); end
    i_pk_ready = 1'b1;
    wait_xfers(PKT, 400, "bp");
    i_pk_ready = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (o_busy !== 1'b1 || o_pk_valid !== 1'b0) bad++;
    end
    checks += 2;
    if (pk_q[0] !== 8'h80) begin errors++; $display("FAIL bp_hdr: got %h want 80", pk_q[0]); end
    if (bad != 0) begin errors++; $display("FAIL bp_gap_hold: %0d cycles left GAP", bad); end
    i_pk_ready = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_arb: busy %b want 0", o_busy); end
    step();
    checks++;
    if (o_pk_valid !== 1'b1 || o_pk_data !== 8'h90) begin
      errors++; $display("FAIL bp_next_hdr: valid %b data %h want 1/90", o_pk_valid, o_pk_data);
    end
    i_src_valid = '0;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    apply_reset();
    i_src_valid = 4'b1000;
    while (src_cnt[3] != 8'd50 && c < 300) begin step(); c++; end
    checks += 2;
    if (src_cnt[3] != 8'd50) begin errors++; $display("FAIL rmid_reach: src3 count %0d want 50", src_cnt[3]); end
    if (pk_q[0] !== 8'h83) begin errors++; $display("FAIL rmid_hdr: got %h want 83", pk_q[0]); end
    #2 i_reset = 1'b1;
    #1;
    checks += 5;
    if (o_pk_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", o_pk_valid); end
    if (o_src_ready !== 4'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0000", o_src_ready); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
    if (o_grant_id !== 2'd3) begin errors++; $display("FAIL rmid_grant: got %0d want 3", o_grant_id); end
    if (o_pk_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", o_pk_data); end
    i_src_valid = 4'b1001;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    wait_xfers(1, 10, "rmid");
    i_src_valid = '0;
    checks++;
    if (pk_q[0] !== 8'h80) begin errors++; $display("FAIL rmid_first_hdr: got %h want 80", pk_q[0]); end
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    i_src_valid = 4'b0001;
    wait_xfers(9 * PKT, 2400, "wrap");
    i_src_valid = '0;
    checks += 3;
    if (pk_q[7*PKT] !== 8'hF0) begin errors++; $display("FAIL wrap_hdr8: got %h want f0", pk_q[7*PKT]); end
    if (pk_q[8*PKT] !== 8'h80) begin errors++; $display("FAIL wrap_hdr9: got %h want 80", pk_q[8*PKT]); end
    if (o_pkt_count !== 16'd9) begin errors++; $display("FAIL wrap_count: got %0d want 9", o_pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_seq_wrap();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
